// File: rtl/fo_verify_ctrl_if.sv
// fo_verify_ctrl_if
//   Groups the signals between the FO verify controller, the ciphertext
//   verify unit and the shared key memory.
//
//   Handshake rules for this bundle:
//   - ver_rst is a level. While it is high the verify unit is held in reset.
//   - The verify unit asserts ver_done, with ver_eq valid, for at least one
//     cycle. It keeps ver_eq stable until ver_rst rises again.
//   - Memory reads are synchronous. The address presented in cycle n returns
//     on mem_din in cycle n+1.
//   - A write happens on every cycle where mem_wr_en=1.
//
//   Modports:
//     master : the controller (drives ver_rst/ver_ilen and the memory port)
//     slave  : the environment (verify unit + memory)
interface fo_verify_ctrl_if;
   logic        ver_rst;
   logic [9:0]  ver_ilen;
   logic [8:0]  ver_rd_addr;
   logic        ver_rd_base_sel;
   logic        ver_done;
   logic        ver_eq;
   logic [8:0]  mem_rd_addr;
   logic        mem_rd_base_sel;
   logic [63:0] mem_din;
   logic        mem_wr_en;
   logic [8:0]  mem_wr_addr;
   logic [63:0] mem_dout;

   modport master (
      output ver_rst, ver_ilen, mem_rd_addr, mem_rd_base_sel,
             mem_wr_en, mem_wr_addr, mem_dout,
      input  ver_rd_addr, ver_rd_base_sel, ver_done, ver_eq, mem_din
   );

   modport slave (
      input  ver_rst, ver_ilen, mem_rd_addr, mem_rd_base_sel,
             mem_wr_en, mem_wr_addr, mem_dout,
      output ver_rd_addr, ver_rd_base_sel, ver_done, ver_eq, mem_din
   );
endinterface

// File: rtl/fo_verify_ctrl.sv
// fo_verify_ctrl
//   Fujisaki-Okamoto re-encryption check controller. It first runs the
//   ciphertext verify unit. It then copies the session key into BASE_OUT,
//   one word at a time. When the ciphertexts matched it copies the
//   re-derived key K'. Otherwise it copies the rejection key z.
//   Both source words are always read, so the selection phase takes
//   3*klen cycles whatever the result is.
//
//   Ports:
//     clk, rst         single clock; asynchronous active-high reset
//     start            one-cycle request, accepted only while busy=0
//     ilen, klen       comparison length / number of 64-bit key words
//     bus (master)     verify-unit control and memory port (fo_verify_ctrl_if)
//     busy             high in every state except IDLE
//     done             one-cycle completion pulse
//     result           1 = ciphertexts equal (K' selected)
//     err              verify watchdog fired
//     dbg_state        current FSM state, for observation only
//
//   Optional build macro: VERIFY_TIMEOUT_EN. When it is defined, a 12-bit
//   watchdog aborts a verify run that lasts {ilen,1'b0}+16 cycles.
//   When it is undefined, VRUN waits indefinitely and err is tied 0.
module fo_verify_ctrl #(
   parameter logic [8:0] BASE_KP  = 9'd0,
   parameter logic [8:0] BASE_Z   = 9'd8,
   parameter logic [8:0] BASE_OUT = 9'd16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [9:0]              ilen,
   input  logic [2:0]              klen,
   fo_verify_ctrl_if.master        bus,
   output logic                    busy,
   output logic                    done,
   output logic                    result,
   output logic                    err,
   output logic [2:0]              dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_VRUN   = 3'd1,
      S_VLATCH = 3'd2,
      S_RD_KP  = 3'd3,
      S_RD_Z   = 3'd4,
      S_WR     = 3'd5,
      S_FIN    = 3'd6
   } state_t;

   state_t      state, state_nxt;
   logic [2:0]  idx;
   logic [2:0]  klen_reg;
   logic [9:0]  ilen_reg;
   logic [63:0] kp_reg;
   logic        timeout;
   logic        last_word;

   assign bus.ver_ilen = ilen_reg;
   assign dbg_state    = state;
   assign last_word    = (idx == (klen_reg - 3'd1));

`ifdef VERIFY_TIMEOUT_EN
   logic [11:0] wd_cnt;
   logic [11:0] wd_limit;

   assign wd_limit = {1'b0, ilen_reg, 1'b0} + 12'd16;
   // The count holds the number of VRUN cycles already completed. The run
   // aborts at the end of the cycle that brings the count to the limit.
   assign timeout  = (state == S_VRUN) && !bus.ver_done && ((wd_cnt + 12'd1) == wd_limit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  wd_cnt <= '0;
      else if (state != S_VRUN) wd_cnt <= '0;
      else                      wd_cnt <= wd_cnt + 12'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          err <= 1'b0;
      else if (state == S_IDLE && start) err <= 1'b0;
      else if (timeout)                 err <= 1'b1;
   end
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt           = state;
      busy                = 1'b1;
      done                = 1'b0;
      bus.ver_rst         = 1'b1;
      bus.mem_rd_addr     = 9'd0;
      bus.mem_rd_base_sel = 1'b0;
      bus.mem_wr_en       = 1'b0;
      bus.mem_wr_addr     = 9'd0;
      bus.mem_dout        = 64'd0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = S_VRUN;
         end
         S_VRUN: begin
            // The verify unit owns the read port only while it is running.
            bus.ver_rst         = 1'b0;
            bus.mem_rd_addr     = bus.ver_rd_addr;
            bus.mem_rd_base_sel = bus.ver_rd_base_sel;
            if (bus.ver_done)  state_nxt = S_VLATCH;
            else if (timeout)  state_nxt = (klen_reg == 3'd0) ? S_FIN : S_RD_KP;
         end
         S_VLATCH: begin
            state_nxt = (klen_reg == 3'd0) ? S_FIN : S_RD_KP;
         end
         S_RD_KP: begin
            bus.mem_rd_addr = BASE_KP + {6'd0, idx};
            state_nxt       = S_RD_Z;
         end
         S_RD_Z: begin
            bus.mem_rd_addr = BASE_Z + {6'd0, idx};
            state_nxt       = S_WR;
         end
         S_WR: begin
            // mem_din carries z[idx] here. K'[idx] was parked in kp_reg one cycle earlier.
            bus.mem_wr_en   = 1'b1;
            bus.mem_wr_addr = BASE_OUT + {6'd0, idx};
            bus.mem_dout    = result ? kp_reg : bus.mem_din;
            state_nxt       = last_word ? S_FIN : S_RD_KP;
         end
         S_FIN: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx      <= 3'd0;
         klen_reg <= 3'd0;
         ilen_reg <= 10'd0;
         kp_reg   <= 64'd0;
         result   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  ilen_reg <= ilen;
                  klen_reg <= klen;
                  result   <= 1'b0;
               end
            end
            S_VRUN: begin
               if (timeout) begin
                  result <= 1'b0;
                  idx    <= 3'd0;
               end
            end
            S_VLATCH: begin
               result <= bus.ver_eq;
               idx    <= 3'd0;
            end
            S_RD_Z: kp_reg <= bus.mem_din;
            S_WR: begin
               if (!last_word) idx <= idx + 3'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fo_verify_ctrl.sv
`timescale 1ns/1ps
module tb_fo_verify_ctrl;
   localparam logic [8:0] BASE_KP  = 9'd0;
   localparam logic [8:0] BASE_Z   = 9'd8;
   localparam logic [8:0] BASE_OUT = 9'd16;
   localparam logic [8:0] CT_BASE  = 9'd32;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [9:0] ilen;
   logic [2:0] klen;
   logic       busy, done, result, err;
   logic [2:0] dbg_state;

   fo_verify_ctrl_if bus ();

   fo_verify_ctrl #(
      .BASE_KP(BASE_KP), .BASE_Z(BASE_Z), .BASE_OUT(BASE_OUT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .ilen(ilen), .klen(klen),
      .bus(bus), .busy(busy), .done(done), .result(result), .err(err),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- memory model (sync read, 1-cycle latency) ----------------
   logic [63:0] buf0 [512];
   logic [63:0] buf1 [512];
   always @(posedge clk)
      bus.mem_din <= bus.mem_rd_base_sel ? buf1[bus.mem_rd_addr] : buf0[bus.mem_rd_addr];

   // ---------------- scoreboard ----------------
   logic [72:0] exp_q[$];     // {addr, data} of each write still expected
   int   errors = 0;
   int   checks = 0;
   int   wr_cnt = 0;
   int   done_cnt = 0;
   int   exp_done_cyc = 0;
   int   done_seen_cyc = 0;
   int   vlatch_cyc = 0;
   logic exp_result = 1'b0;
   logic exp_err = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Compare process: checks every write and every done pulse.
   always @(negedge clk) begin
      logic [72:0] e;
      if (bus.mem_wr_en === 1'b1) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_unexpected: addr %0d data %h, no write expected", bus.mem_wr_addr, bus.mem_dout);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(bus.mem_wr_addr), 64'(e[72:64]));
            chk("wr_data", bus.mem_dout, e[63:0]);
         end
      end
      if (done === 1'b1) begin
         done_cnt++;
         done_seen_cyc = cyc;
         chk("done_cycle", 64'(cyc), 64'(exp_done_cyc));
         chk("done_result", 64'(result), 64'(exp_result));
         chk("done_err", 64'(err), 64'(exp_err));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load(input bit flip);
      for (int k = 0; k < 8; k++) begin
         buf0[BASE_KP + 9'(k)] = {8{8'h11}} ^ 64'(k);
         buf0[BASE_Z + 9'(k)]  = {8{8'h22}} ^ 64'(k);
      end
      for (int j = 0; j < 16; j++) begin
         buf0[CT_BASE + 9'(j)] = 64'hC0DE_0000_0000_0000 | 64'(j * 7 + 1);
         buf1[CT_BASE + 9'(j)] = 64'hC0DE_0000_0000_0000 | 64'(j * 7 + 1);
      end
      if (flip) buf1[CT_BASE + 9'd2] = buf1[CT_BASE + 9'd2] ^ (64'd1 << 17);
   endtask

   // Spec-level model: word k of the session key is K'[k] on a match, else z[k].
   task automatic expect_writes(input int kl, input bit res);
      logic [8:0] wa;
      for (int k = 0; k < kl; k++) begin
         wa = BASE_OUT + 9'(k);
         exp_q.push_back({wa, res ? buf0[BASE_KP + 9'(k)] : buf0[BASE_Z + 9'(k)]});
      end
   endtask

   task automatic do_start(input logic [9:0] il, input logic [2:0] kl);
      ilen  = il;
      klen  = kl;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("ver_ilen_capture", 64'(bus.ver_ilen), 64'(il));
   endtask

   // Behavioural verify unit: compares n words of both buffers through the
   // controller's read mux, then reports done/eq.
   task automatic run_verify(input int n, input int kl, input bit poke);
      logic [63:0] a, b;
      bit eq;
      int t;
      eq = 1'b1;
      t  = 0;
      while (bus.ver_rst !== 1'b0 && t < 20) begin @(negedge clk); t++; end
      chk("vrun_entry", 64'(bus.ver_rst), 64'd0);
      for (int j = 0; j < n; j++) begin
         bus.ver_rd_addr     = CT_BASE + 9'(j);
         bus.ver_rd_base_sel = 1'b0;
         @(negedge clk);
         a = bus.mem_din;
         bus.ver_rd_base_sel = 1'b1;
         if (poke && j == 0) begin start = 1'b1; ilen = 10'd9; end
         @(negedge clk);
         start = 1'b0;
         b = bus.mem_din;
         if (a !== b) eq = 1'b0;
      end
      bus.ver_eq   = eq;
      bus.ver_done = 1'b1;
      vlatch_cyc   = cyc + 1;
      exp_done_cyc = cyc + 2 + 3 * kl;
      @(negedge clk);
      bus.ver_done = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      int t;
      t = 0;
      while (done_cnt == d0 && t < 200) begin @(negedge clk); t++; end
      chk("done_seen", 64'(done_cnt), 64'(d0 + 1));
      repeat (4) @(negedge clk);
      chk("done_once", 64'(done_cnt), 64'(d0 + 1));
      chk("idle_busy", 64'(busy), 64'd0);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int d0, w0, lat1, t, n;
      rst = 1'b1; start = 1'b0; ilen = '0; klen = '0;
      bus.ver_rd_addr = '0; bus.ver_rd_base_sel = 1'b0;
      bus.ver_done = 1'b0; bus.ver_eq = 1'b0;
      #2;
      chk("rst_ver_rst", 64'(bus.ver_rst), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_wr_en", 64'(bus.mem_wr_en), 64'd0);
      chk("rst_rd_addr", 64'(bus.mem_rd_addr), 64'd0);
      chk("rst_wr_addr", 64'(bus.mem_wr_addr), 64'd0);
      chk("rst_dout", bus.mem_dout, 64'd0);
      chk("rst_ver_ilen", 64'(bus.ver_ilen), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Equal buffers, klen=4: K' words written
      load(1'b0);
      exp_result = 1'b1; exp_err = 1'b0;
      expect_writes(4, 1'b1);
      chk("model_first_kp", exp_q[0][63:0], 64'h1111_1111_1111_1111);
      chk("model_last_kp", exp_q[3][63:0], 64'h1111_1111_1111_1112);
      chk("model_last_addr", 64'(exp_q[3][72:64]), 64'd19);
      d0 = done_cnt; w0 = wr_cnt;
      do_start(10'd3, 3'd4);
      run_verify(3, 4, 1'b0);
      wait_done(d0);
      chk("eq_writes", 64'(wr_cnt - w0), 64'd4);
      chk("eq_result_hold", 64'(result), 64'd1);
      chk("eq_err", 64'(err), 64'd0);
      lat1 = done_seen_cyc - vlatch_cyc;
      chk("eq_latency", 64'(lat1), 64'd13);

      // One bit flipped in word 2: z words, same latency
      load(1'b1);
      exp_result = 1'b0; exp_err = 1'b0;
      expect_writes(4, 1'b0);
      chk("model_first_z", exp_q[0][63:0], 64'h2222_2222_2222_2222);
      d0 = done_cnt; w0 = wr_cnt;
      do_start(10'd3, 3'd4);
      run_verify(3, 4, 1'b0);
      wait_done(d0);
      chk("ne_writes", 64'(wr_cnt - w0), 64'd4);
      chk("ne_result_hold", 64'(result), 64'd0);
      chk("ne_latency_same", 64'(done_seen_cyc - vlatch_cyc), 64'(lat1));

      // klen=0: no writes, done one cycle after VLATCH
      load(1'b0);
      exp_result = 1'b1; exp_err = 1'b0;
      d0 = done_cnt; w0 = wr_cnt;
      do_start(10'd3, 3'd0);
      run_verify(3, 0, 1'b0);
      wait_done(d0);
      chk("k0_writes", 64'(wr_cnt - w0), 64'd0);
      chk("k0_latency", 64'(done_seen_cyc - vlatch_cyc), 64'd1);
      chk("k0_result", 64'(result), 64'd1);

      // start pulsed again in VRUN and in WR: ignored
      load(1'b0);
      exp_result = 1'b1; exp_err = 1'b0;
      expect_writes(2, 1'b1);
      d0 = done_cnt; w0 = wr_cnt;
      do_start(10'd3, 3'd2);
      run_verify(3, 2, 1'b1);
      chk("poke_vrun_ilen", 64'(bus.ver_ilen), 64'd3);
      t = 0;
      while (bus.mem_wr_en !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      chk("poke_wr_reached", 64'(bus.mem_wr_en), 64'd1);
      start = 1'b1; ilen = 10'd7;
      @(negedge clk);
      start = 1'b0;
      wait_done(d0);
      chk("poke_ver_ilen", 64'(bus.ver_ilen), 64'd3);
      chk("poke_writes", 64'(wr_cnt - w0), 64'd2);

      // Reset during RD_Z of word 1
      load(1'b0);
      exp_result = 1'b1; exp_err = 1'b0;
      expect_writes(4, 1'b1);
      d0 = done_cnt; w0 = wr_cnt;
      do_start(10'd3, 3'd4);
      run_verify(3, 4, 1'b0);
      t = 0;
      while (!(bus.mem_rd_addr === (BASE_Z + 9'd1) && bus.ver_rst === 1'b1) && t < 50) begin
         @(negedge clk); t++;
      end
      chk("rdz1_reached", 64'(bus.mem_rd_addr), 64'(BASE_Z + 9'd1));
      #1 rst = 1'b1;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_ver_rst", 64'(bus.ver_rst), 64'd1);
      chk("midrst_wr_en", 64'(bus.mem_wr_en), 64'd0);
      chk("midrst_result", 64'(result), 64'd0);
      exp_q.delete();
      chk("midrst_writes", 64'(wr_cnt - w0), 64'd1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("postrst_writes", 64'(wr_cnt - w0), 64'd1);
      chk("postrst_done", 64'(done_cnt - d0), 64'd0);
      expect_writes(4, 1'b1);
      d0 = done_cnt; w0 = wr_cnt;
      do_start(10'd3, 3'd4);
      run_verify(3, 4, 1'b0);
      wait_done(d0);
      chk("recover_writes", 64'(wr_cnt - w0), 64'd4);

`ifdef VERIFY_TIMEOUT_EN
      // Watchdog: ilen=4, ver_done never arrives
      load(1'b0);
      exp_result = 1'b0; exp_err = 1'b1;
      expect_writes(4, 1'b0);
      d0 = done_cnt; w0 = wr_cnt;
      do_start(10'd4, 3'd4);
      n = 1; t = 0;
      while (bus.ver_rst === 1'b0 && t < 100) begin @(negedge clk); n++; t++; end
      n = n - 1;
      exp_done_cyc = cyc + 12;
      chk("wd_vrun_cycles", 64'(n), 64'd24);
      wait_done(d0);
      chk("wd_err", 64'(err), 64'd1);
      chk("wd_result", 64'(result), 64'd0);
      chk("wd_writes", 64'(wr_cnt - w0), 64'd4);
`else
      n = 0;
`endif

      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/fo_verify_ctrl.md
FO_VERIFY_CTRL -- requirements
Module: fo_verify_ctrl

Interface
REQ-001 Parameters: BASE_KP, 9'd0, read base of re-derived key K'; BASE_Z, 9'd8, read base of rejection key z; BASE_OUT, 9'd16, write base of session key.
REQ-002 clk  in  1  single clock; all flops on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  one-cycle request; honoured only in IDLE.
REQ-005 ilen  in  10  comparison length, forwarded to the verify unit.
REQ-006 klen  in  3  number of 64-bit key words to select (0..7).
REQ-007 ver_rst  out  1  synchronous reset to the verify unit; high = held.
REQ-008 ver_ilen  out  10  registered copy of ilen, captured at start.
REQ-009 ver_rd_addr  in  9; ver_rd_base_sel  in  1; verify unit read request.
REQ-010 ver_done  in  1; ver_eq  in  1 (1 = ciphertexts equal).
REQ-011 mem_rd_addr  out  9; mem_rd_base_sel  out  1; mem_din  in  64 (sync read, 1-cycle latency).
REQ-012 mem_wr_en  out  1; mem_wr_addr  out  9; mem_dout  out  64.
REQ-013 busy  out  1; done  out  1 (one-cycle pulse); result  out  1; err  out  1.

Function
REQ-014 States: IDLE, VRUN, VLATCH, RD_KP, RD_Z, WR, FIN.
REQ-015 IDLE: ver_rst=1, busy=0; start -> capture ilen/klen, clear result/err, go VRUN next cycle.
REQ-016 VRUN: ver_rst=0; memory read port muxed to ver_rd_addr/ver_rd_base_sel; stay until ver_done=1, then VLATCH.
REQ-017 VLATCH: result <= ver_eq; ver_rst=1; word index i <= 0; klen==0 -> FIN, else RD_KP.
REQ-018 Outside VRUN the controller owns the read port; mem_rd_base_sel=0.
REQ-019 RD_KP: mem_rd_addr = BASE_KP+i; next RD_Z.
REQ-020 RD_Z: mem_rd_addr = BASE_Z+i; kp_reg <= mem_din; next WR.
REQ-021 WR: mem_wr_en=1, mem_wr_addr = BASE_OUT+i, mem_dout = result ? kp_reg : mem_din; i==klen-1 -> FIN, else i++ and RD_KP.
REQ-022 Both K' and z words are always read regardless of result; selection cycle count is exactly 3*klen, independent of result.
REQ-023 Address arithmetic is 9-bit modulo 512; wrap is not flagged.
REQ-024 FIN: done=1 for one cycle, then IDLE; result/err hold until next accepted start.
REQ-025 busy=1 in every state except IDLE; start while busy is ignored with no side effect.
REQ-026 mem_wr_en=0 in every state except WR.

Reset
REQ-027 rst asserted at any time (including mid-run) -> state IDLE within the same cycle, without waiting for a clock edge.
REQ-028 Reset values: ver_rst=1, busy=0, done=0, result=0, err=0, mem_wr_en=0, mem_rd_addr=0, mem_wr_addr=0, mem_dout=0, i=0, ver_ilen=0.

Configuration
REQ-029 Macro VERIFY_TIMEOUT_EN defined: 12-bit watchdog cleared on VRUN entry; if count reaches {ilen,1'b0}+16 with ver_done=0 -> err=1, result forced 0, go to RD_KP (or FIN if klen==0), ver_rst=1.
REQ-030 VERIFY_TIMEOUT_EN undefined: no watchdog logic; VRUN waits indefinitely; err is tied 0.

Verification
REQ-031 ilen=3, equal buffers, klen=4, K'=0x11..,z=0x22.. -> result=1, 4 writes of K' words to BASE_OUT..+3, done once, no err.
REQ-032 ilen=3, single bit flipped in word 2 -> result=0, 4 writes of z words; cycle count from VLATCH to done identical to REQ-031.
REQ-033 klen=0, equal buffers -> result=1, zero writes, done one cycle after VLATCH.
REQ-034 start pulsed again in VRUN and in WR -> no restart, ver_ilen unchanged, exactly one done.
REQ-035 rst asserted during RD_Z of word 1 -> immediate IDLE, ver_rst=1, mem_wr_en=0, no further writes; subsequent start completes normally.
REQ-036 VERIFY_TIMEOUT_EN defined, ilen=4, ver_done held 0 -> err=1 after 24 VRUN cycles, result=0, z words written, done pulsed.
